// File: rtl/bomb_placer.sv
// Decodes a one-hot bomb-count code and fills an 8x8 bitmap with that many bombs at
// non-repeating pseudo-random cells taken from a free-running 8-bit LFSR.
module bomb_placer #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  count_code,
  output logic        busy,
  output logic        done,
  output logic        code_error,
  output logic [63:0] bomb_map,
  output logic [6:0]  placed_count
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0] SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {StIdle, StClear, StPlace, StDone} state_t;

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [6:0]  r_target;
  logic [63:0] r_map;
  logic [6:0]  r_placed;
  logic        r_busy;
  logic        r_done;
  logic        r_code_error;

  logic        w_valid;
  logic [6:0]  w_target;
  logic        w_fb;
  logic [5:0]  w_cell;
  logic [6:0]  w_placed_inc;

  always_comb begin
    w_valid  = 1'b1;
    w_target = 7'd0;
    case (count_code)
      6'b000010: w_target = 7'd2;
      6'b000100: w_target = 7'd4;
      6'b001000: w_target = 7'd8;
      6'b010000: w_target = 7'd16;
      6'b100000: w_target = 7'd32;
      6'b111111: w_target = 7'd63;
      default:   w_valid  = 1'b0;
    endcase
  end

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cell       = r_lfsr[5:0];
  assign w_placed_inc = r_placed + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SeedEff;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_target     <= 7'd0;
      r_map        <= 64'd0;
      r_placed     <= 7'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_code_error <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_code_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start && w_valid) begin
            r_target <= w_target;
            r_busy   <= 1'b1;
            r_state  <= StClear;
          end else if (start) begin
            r_code_error <= 1'b1;
          end
        end
        StClear: begin
          r_map    <= 64'd0;
          r_placed <= 7'd0;
          r_state  <= StPlace;
        end
        StPlace: begin
          // An occupied cell is simply skipped; the LFSR advances regardless.
          if (!r_map[w_cell]) begin
            r_map[w_cell] <= 1'b1;
            r_placed      <= w_placed_inc;
            if (w_placed_inc == r_target) begin
              r_busy  <= 1'b0;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign code_error   = r_code_error;
  assign bomb_map     = r_map;
  assign placed_count = r_placed;

endmodule
